alu_param: RTL and testbench

ALU_PARAM -- requirements
Module: alu_param

---
 rtl/alu_param.sv | 139 +++++++++++++
 tb/tb_alu_param.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_param.sv
// Multi-cycle parameterised ALU: single-cycle add/sub/AND, shift-add multiply over WIDTH cycles.
// Optional zero/carry flags are built only when ALU_PARAM_FLAGS_EN is defined.
module alu_param #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [1:0]         sel,
  input  logic               CI,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] cout,
  output logic               zero,
  output logic               carry
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpAnd = 2'b11;

  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_next;
  logic [2*WIDTH-1:0] cout_q, cout_d;
  logic [2*WIDTH-1:0] op_res, wr_val;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]     sum;
  logic               launch, mul_last, wr_en;

  assign sum      = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, CI};
  assign launch   = (state_q == StIdle) && start;
  assign mul_last = (state_q == StMul) && (cnt_q == CntW'(WIDTH - 1));
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Results are written either on the launch edge (single-cycle ops) or on the last MUL edge.
  assign wr_en  = (launch && (sel != OpMul)) || mul_last;
  assign wr_val = (state_q == StMul) ? acc_next : op_res;

  always_comb begin
    op_res = '0;
    unique case (sel)
      OpAdd:   op_res = {{(WIDTH - 1){1'b0}}, sum};
      OpSub:   op_res = {{WIDTH{1'b0}}, A - B};
      OpMul:   op_res = '0;
      OpAnd:   op_res = {{WIDTH{1'b0}}, A & B};
      default: op_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, A};
          mplier_d = B;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = (sel == OpMul) ? StMul : StDone;
        end
      end
      StMul: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (mul_last) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign cout_d = wr_en ? wr_val : cout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      cout_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      cout_q   <= cout_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign cout = cout_q;

`ifdef ALU_PARAM_FLAGS_EN
  logic zero_q, zero_d, carry_q, carry_d, op_carry;

  // Carry is only meaningful for add (carry-out) and subtract (borrow); multiply writes 0.
  assign op_carry = (sel == OpAdd) ? sum[WIDTH] :
                    (sel == OpSub) ? (A < B)    : 1'b0;
  assign zero_d   = wr_en ? (wr_val == '0) : zero_q;
  assign carry_d  = wr_en ? (launch & op_carry) : carry_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign zero  = zero_q;
  assign carry = carry_q;
`else
  assign zero  = 1'b0;
  assign carry = 1'b0;
`endif

endmodule

// File: tb/tb_alu_param.sv
// Self-checking bench for alu_param (WIDTH=4): vector table, corner sequences, random ops,
// with expected results queued at launch and compared when done appears.
module tb_alu_param;

`ifdef ALU_PARAM_FLAGS_EN
  localparam bit FlagsEn = 1'b1;
`else
  localparam bit FlagsEn = 1'b0;
`endif

  logic       clk, rst, start, CI;
  logic [3:0] A, B;
  logic [1:0] sel;
  logic       busy, done, zero, carry;
  logic [7:0] cout;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] sel;
    logic       ci;
    logic [7:0] cout;
    logic       z;
    logic       c;
  } vec_t;

  typedef struct {
    logic [7:0] cout;
    logic       z;
    logic       c;
    int         lat;
  } exp_t;

  vec_t vecs[12];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  alu_param #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .sel   (sel),
    .CI    (CI),
    .start (start),
    .busy  (busy),
    .done  (done),
    .cout  (cout),
    .zero  (zero),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] c, input logic z, input logic cy, input int lat);
    exp_t e;
    e.cout = c;
    e.z    = z & FlagsEn;
    e.c    = cy & FlagsEn;
    e.lat  = lat;
    exp_q.push_back(e);
  endtask

  // Drives a one-cycle start; returns at the negedge of the first cycle after the start edge.
  task automatic launch(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s,
                        input logic c);
    @(negedge clk);
    A = a; B = b; sel = s; CI = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic collect(input string nm, input int cyc0);
    int   cyc;
    exp_t e;
    cyc = cyc0;
    while (done !== 1'b1 && cyc < 40) begin
      chk({nm, "_busy_wait"}, 16'(busy), 16'd1);
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) begin
      chk({nm, "_done_timeout"}, 16'(done), 16'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      chk({nm, "_unexpected_done"}, 16'd1, 16'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({nm, "_latency"}, 16'(cyc), 16'(e.lat));
    chk({nm, "_cout"}, 16'(cout), 16'(e.cout));
    chk({nm, "_zero"}, 16'(zero), 16'(e.z));
    chk({nm, "_carry"}, 16'(carry), 16'(e.c));
    chk({nm, "_busy_done"}, 16'(busy), 16'd1);
    @(negedge clk);
    chk({nm, "_done_pulse"}, 16'(done), 16'd0);
    chk({nm, "_busy_idle"}, 16'(busy), 16'd0);
  endtask

  function automatic exp_t model(input int a, input int b, input int s, input int ci);
    exp_t e;
    int   r;
    e.c   = 1'b0;
    e.lat = 1;
    r     = 0;
    case (s)
      0: begin r = a + b + ci; e.c = (r > 15); end
      1: begin r = (a - b) & 15; e.c = (a < b); end
      2: begin r = a * b; e.lat = 5; end
      default: r = a & b;
    endcase
    e.cout = 8'(r);
    e.z    = (r == 0);
    return e;
  endfunction

  initial begin
    exp_t m;
    int   ndone;
    vecs[0]  = '{4'd9,  4'd8,  2'b00, 1'b1, 8'h12, 1'b0, 1'b1};
    vecs[1]  = '{4'd3,  4'd5,  2'b01, 1'b0, 8'h0E, 1'b0, 1'b1};
    vecs[2]  = '{4'd5,  4'd5,  2'b01, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{4'hA,  4'h5,  2'b11, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[4]  = '{4'd15, 4'd15, 2'b00, 1'b1, 8'h1F, 1'b0, 1'b1};
    vecs[5]  = '{4'd0,  4'd0,  2'b00, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{4'd7,  4'd6,  2'b10, 1'b0, 8'h2A, 1'b0, 1'b0};
    vecs[7]  = '{4'd0,  4'd9,  2'b10, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{4'hF,  4'hC,  2'b11, 1'b0, 8'h0C, 1'b0, 1'b0};
    vecs[9]  = '{4'd3,  4'd4,  2'b00, 1'b0, 8'h07, 1'b0, 1'b0};
    vecs[10] = '{4'd15, 4'd0,  2'b01, 1'b0, 8'h0F, 1'b0, 1'b0};
    vecs[11] = '{4'd13, 4'd11, 2'b10, 1'b0, 8'h8F, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; A = '0; B = '0; sel = '0; CI = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 16'(busy), 16'd0);
    chk("reset_done", 16'(done), 16'd0);
    chk("reset_cout", 16'(cout), 16'd0);
    chk("reset_zero", 16'(zero), 16'd0);
    chk("reset_carry", 16'(carry), 16'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].ci);
      push(vecs[i].cout, vecs[i].z, vecs[i].c, (vecs[i].sel == 2'b10) ? 5 : 1);
      collect($sformatf("vec%0d", i), 1);
    end

    // Start pulsed mid-multiply must be ignored.
    launch(4'd15, 4'd15, 2'b10, 1'b0);
    push(8'hE1, 1'b0, 1'b0, 5);
    @(negedge clk);
    A = 4'd1; B = 4'd1; sel = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect("mul_ignore", 3);
    chk("mul_ignore_no_relaunch", 16'(busy), 16'd0);

    // Results hold while inputs wiggle without start.
    launch(4'd9, 4'd8, 2'b00, 1'b1);
    push(8'h12, 1'b0, 1'b1, 1);
    collect("hold_add", 1);
    for (int i = 0; i < 3; i++) begin
      A = 4'(i * 5); B = 4'(15 - i); sel = 2'(i); CI = ~CI;
      @(negedge clk);
    end
    chk("hold_cout", 16'(cout), 16'h12);
    chk("hold_carry", 16'(carry), 16'(FlagsEn));
    chk("hold_busy", 16'(busy), 16'd0);

    // Reset wins over start on the same edge.
    @(negedge clk);
    A = 4'd1; B = 4'd1; sel = 2'b00; start = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    chk("rst_prio_busy", 16'(busy), 16'd0);
    chk("rst_prio_cout", 16'(cout), 16'd0);
    chk("rst_prio_carry", 16'(carry), 16'd0);

    // Reset in the second MUL cycle aborts the multiply.
    launch(4'd7, 4'd6, 2'b10, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    chk("abort_cout", 16'(cout), 16'd0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", 16'(ndone), 16'd0);
    launch(4'd2, 4'd2, 2'b00, 1'b0);
    push(8'h04, 1'b0, 1'b0, 1);
    collect("after_abort_add", 1);

    for (int i = 0; i < 16; i++) begin
      int ra, rb, rs, rc;
      ra = int'($urandom_range(15));
      rb = int'($urandom_range(15));
      rs = int'($urandom_range(3));
      rc = int'($urandom_range(1));
      m  = model(ra, rb, rs, rc);
      launch(4'(ra), 4'(rb), 2'(rs), 1'(rc));
      push(m.cout, m.z, m.c, m.lat);
      collect($sformatf("rand%0d_op%0d", i, rs), 1);
    end

    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
